// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus: the memory stage drives requests (master),
// the data memory answers them (slave).
interface mem_access_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_data;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_wdata,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_wdata,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: accepts EX/MEM entries, runs one data-memory access at a time and
// emits a MEM/WB pulse. Alignment checking is enabled by defining MEM_ACCESS_MISALIGN_CHECK_EN.
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               EXMEM_ready,
  input  logic [63:0]        exmm_aluresult,
  input  logic [5:0]         dest_reg,
  input  logic               mem_active,
  input  logic               load,
  input  logic [1:0]         mem_size,
  input  logic               mem_unsigned,
  input  logic [63:0]        store_data,
  output logic               mem_busy,
  mem_access_stage_if.master mem,
  output logic               MEMWB_ready,
  output logic [5:0]         wb_rd,
  output logic [63:0]        wb_data,
  output logic               bus_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitResp} state_e;

  state_e      state_q;
  logic [15:0] wait_cnt_q;
  logic [16:0] wait_cnt_inc;
  logic [5:0]  rd_q;
  logic        unsigned_q;
  logic [63:0] load_ext;
  logic        accept;

  assign accept       = EXMEM_ready && !mem_busy;
  assign wait_cnt_inc = {1'b0, wait_cnt_q} + 17'd1;

  // req_size keeps the latched access size for the whole transaction.
  always_comb begin
    load_ext = mem.resp_data;
    case (mem.req_size)
      2'd0:    load_ext = {{56{~unsigned_q & mem.resp_data[7]}}, mem.resp_data[7:0]};
      2'd1:    load_ext = {{48{~unsigned_q & mem.resp_data[15]}}, mem.resp_data[15:0]};
      2'd2:    load_ext = {{32{~unsigned_q & mem.resp_data[31]}}, mem.resp_data[31:0]};
      default: load_ext = mem.resp_data;
    endcase
  end

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (mem_size)
      2'd1:    misaligned = exmm_aluresult[0];
      2'd2:    misaligned = |exmm_aluresult[1:0];
      2'd3:    misaligned = |exmm_aluresult[2:0];
      default: misaligned = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      rd_q          <= '0;
      unsigned_q    <= 1'b0;
      mem_busy      <= 1'b0;
      mem.req_valid <= 1'b0;
      mem.req_we    <= 1'b0;
      mem.req_addr  <= '0;
      mem.req_size  <= '0;
      mem.req_wdata <= '0;
      MEMWB_ready   <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      bus_err       <= 1'b0;
    end else begin
      MEMWB_ready <= 1'b0;
      bus_err     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (!mem_active) begin
              MEMWB_ready <= 1'b1;
              wb_rd       <= dest_reg;
              wb_data     <= exmm_aluresult;
            end
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
            else if (misaligned) begin
              MEMWB_ready <= 1'b1;
              bus_err     <= 1'b1;
              wb_rd       <= '0;
            end
`endif
            else begin
              state_q       <= StIssue;
              mem_busy      <= 1'b1;
              mem.req_valid <= 1'b1;
              mem.req_we    <= ~load;
              mem.req_addr  <= exmm_aluresult;
              mem.req_size  <= mem_size;
              mem.req_wdata <= store_data;
              unsigned_q    <= mem_unsigned;
              rd_q          <= dest_reg;
            end
          end
        end
        StIssue: begin
          if (mem.req_ready) begin
            mem.req_valid <= 1'b0;
            if (mem.req_we) begin
              state_q     <= StIdle;
              mem_busy    <= 1'b0;
              MEMWB_ready <= 1'b1;
              wb_rd       <= '0;
            end else begin
              state_q    <= StWaitResp;
              wait_cnt_q <= '0;
            end
          end
        end
        StWaitResp: begin
          wait_cnt_q <= wait_cnt_inc[15:0];
          if (mem.resp_valid) begin
            state_q     <= StIdle;
            mem_busy    <= 1'b0;
            MEMWB_ready <= 1'b1;
            wb_rd       <= rd_q;
            wb_data     <= load_ext;
          end else if (wait_cnt_inc >= 17'(MAX_WAIT)) begin
            // Timeout retires the entry with no writeback so the pipeline keeps moving.
            state_q     <= StIdle;
            mem_busy    <= 1'b0;
            MEMWB_ready <= 1'b1;
            bus_err     <= 1'b1;
            wb_rd       <= '0;
          end
        end
        default: begin
          state_q  <= StIdle;
          mem_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: hand-computed vectors plus a transaction-level
// writeback model checked on every cycle.
module tb_mem_access_stage;
  localparam int unsigned MaxWait = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        EXMEM_ready;
  logic [63:0] exmm_aluresult;
  logic [5:0]  dest_reg;
  logic        mem_active;
  logic        load;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [63:0] store_data;
  logic        mem_busy;
  logic        MEMWB_ready;
  logic [5:0]  wb_rd;
  logic [63:0] wb_data;
  logic        bus_err;

  mem_access_stage_if mem ();

  mem_access_stage #(.MAX_WAIT(MaxWait)) dut (
    .clk            (clk),
    .reset          (reset),
    .EXMEM_ready    (EXMEM_ready),
    .exmm_aluresult (exmm_aluresult),
    .dest_reg       (dest_reg),
    .mem_active     (mem_active),
    .load           (load),
    .mem_size       (mem_size),
    .mem_unsigned   (mem_unsigned),
    .store_data     (store_data),
    .mem_busy       (mem_busy),
    .mem            (mem),
    .MEMWB_ready    (MEMWB_ready),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0]  rd;
    logic [63:0] data;
    bit          chk_data;
    bit          err;
  } wb_exp_t;

  wb_exp_t exp_q[$];

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0b want %0b", name, act, want);
    end
  endtask

  // Load extension from the access width: mask to the width, then fill with the top bit.
  function automatic logic [63:0] ext_model(input logic [63:0] raw, input int size, input bit uns);
    int          nbits = 8 << size;
    logic [63:0] mask;
    logic [63:0] v;
    if (nbits == 64) return raw;
    mask = (64'd1 << nbits) - 64'd1;
    v    = raw & mask;
    if (!uns && raw[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic push_exp(input logic [5:0] rd, input logic [63:0] data, input bit chk_data,
                          input bit err);
    exp_q.push_back('{rd: rd, data: data, chk_data: chk_data, err: err});
  endtask

  // Every writeback pulse must match the next modelled retirement; bus_err only with a pulse.
  always @(negedge clk) begin
    if (MEMWB_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL memwb_unexpected: got pulse rd=%0d want no pulse", wb_rd);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        chk64("memwb_rd", 64'(wb_rd), 64'(e.rd));
        if (e.chk_data) chk64("memwb_data", wb_data, e.data);
        chk1("memwb_err", bus_err, e.err);
      end
    end else begin
      chk1("bus_err_no_pulse", bus_err, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_alu(input logic [63:0] v, input logic [5:0] rd);
    EXMEM_ready    = 1'b1;
    mem_active     = 1'b0;
    exmm_aluresult = v;
    dest_reg       = rd;
    push_exp(rd, v, 1'b1, 1'b0);
    tick();
  endtask

  // Full memory transaction; starts and ends just after a rising edge with the stage idle.
  task automatic mem_op(input logic [63:0] addr, input logic [1:0] size, input bit uns,
                        input bit is_load, input logic [5:0] rd, input logic [63:0] wdata,
                        input int stall, input int resp_wait, input bit respond,
                        input logic [63:0] rdata);
    EXMEM_ready    = 1'b1;
    mem_active     = 1'b1;
    load           = is_load;
    mem_size       = size;
    mem_unsigned   = uns;
    exmm_aluresult = addr;
    dest_reg       = rd;
    store_data     = wdata;
    mem.req_ready  = 1'b0;
    tick();
    // Scramble the EX/MEM inputs to prove the stage latched them.
    EXMEM_ready    = 1'b0;
    exmm_aluresult = '1;
    store_data     = 64'h5555_5555_5555_5555;
    dest_reg       = 6'h3f;
    mem_size       = ~size;
    mem_unsigned   = ~uns;
    load           = ~is_load;
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      chk1("req_valid", mem.req_valid, 1'b1);
      chk64("req_addr", mem.req_addr, addr);
      chk1("req_we", mem.req_we, ~is_load);
      chk64("req_size", 64'(mem.req_size), 64'(size));
      if (!is_load) chk64("req_wdata", mem.req_wdata, wdata);
      chk1("busy_issue", mem_busy, 1'b1);
      if (i < stall) begin
        mem.resp_valid = 1'b1;
        mem.resp_data  = 64'h0bad_0bad_0bad_0bad;
        tick();
      end else begin
        mem.resp_valid = 1'b0;
        mem.req_ready  = 1'b1;
        if (!is_load) push_exp(6'd0, 64'd0, 1'b0, 1'b0);
        tick();
        mem.req_ready = 1'b0;
      end
    end
    if (!is_load) begin
      @(negedge clk);
      chk1("store_memwb", MEMWB_ready, 1'b1);
      chk1("store_idle", mem_busy, 1'b0);
      chk1("store_req_low", mem.req_valid, 1'b0);
      tick();
    end else if (respond) begin
      for (int k = 0; k < resp_wait; k++) begin
        @(negedge clk);
        chk1("wait_busy", mem_busy, 1'b1);
        chk1("wait_no_wb", MEMWB_ready, 1'b0);
        chk1("wait_req_low", mem.req_valid, 1'b0);
        tick();
      end
      mem.resp_valid = 1'b1;
      mem.resp_data  = rdata;
      push_exp(rd, ext_model(rdata, int'(size), uns), 1'b1, 1'b0);
      tick();
      mem.resp_valid = 1'b0;
      @(negedge clk);
      chk1("load_memwb", MEMWB_ready, 1'b1);
      chk1("load_idle", mem_busy, 1'b0);
      tick();
    end else begin
      push_exp(6'd0, 64'd0, 1'b0, 1'b1);
      for (int k = 0; k < int'(MaxWait); k++) begin
        @(negedge clk);
        chk1("tmo_busy", mem_busy, 1'b1);
        chk1("tmo_no_wb", MEMWB_ready, 1'b0);
        tick();
      end
      @(negedge clk);
      chk1("tmo_memwb", MEMWB_ready, 1'b1);
      chk1("tmo_bus_err", bus_err, 1'b1);
      chk64("tmo_wb_rd", 64'(wb_rd), 64'd0);
      chk1("tmo_idle", mem_busy, 1'b0);
      tick();
    end
  endtask

  initial begin
    reset          = 1'b0;
    EXMEM_ready    = 1'b0;
    exmm_aluresult = '0;
    dest_reg       = '0;
    mem_active     = 1'b0;
    load           = 1'b0;
    mem_size       = '0;
    mem_unsigned   = 1'b0;
    store_data     = '0;
    mem.req_ready  = 1'b0;
    mem.resp_valid = 1'b0;
    mem.resp_data  = '0;

    // Reset values.
    tick();
    tick();
    @(negedge clk);
    chk1("rst_busy", mem_busy, 1'b0);
    chk1("rst_req_valid", mem.req_valid, 1'b0);
    chk1("rst_req_we", mem.req_we, 1'b0);
    chk64("rst_req_addr", mem.req_addr, 64'd0);
    chk64("rst_req_size", 64'(mem.req_size), 64'd0);
    chk64("rst_req_wdata", mem.req_wdata, 64'd0);
    chk1("rst_memwb", MEMWB_ready, 1'b0);
    chk64("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk64("rst_wb_data", wb_data, 64'd0);
    chk1("rst_bus_err", bus_err, 1'b0);
    tick();
    reset = 1'b1;

    // Non-memory entry, then hold of wb_* after the pulse.
    send_alu(64'h1234, 6'd5);
    EXMEM_ready = 1'b0;
    @(negedge clk);
    chk1("alu_memwb", MEMWB_ready, 1'b1);
    chk64("alu_wb_rd", 64'(wb_rd), 64'd5);
    chk64("alu_wb_data", wb_data, 64'h1234);
    tick();
    @(negedge clk);
    chk1("alu_pulse_end", MEMWB_ready, 1'b0);
    chk64("alu_hold_rd", 64'(wb_rd), 64'd5);
    chk64("alu_hold_data", wb_data, 64'h1234);
    tick();

    // Back-to-back non-memory entries.
    send_alu(64'hAAAA_0000_0000_0001, 6'd1);
    send_alu(64'hBBBB_0000_0000_0002, 6'd2);
    send_alu(64'hCCCC_0000_0000_0003, 6'd0);
    EXMEM_ready = 1'b0;
    @(negedge clk);
    chk1("b2b_last_memwb", MEMWB_ready, 1'b1);
    chk64("b2b_last_data", wb_data, 64'hCCCC_0000_0000_0003);
    tick();

    // Signed byte load with a 3-cycle request stall and stray resp_valid during ISSUE.
    mem_op(64'h100, 2'd0, 1'b0, 1'b1, 6'd7, 64'd0, 3, 0, 1'b1, 64'h80);
    @(negedge clk);
    chk64("sbyte_lit_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk64("sbyte_lit_rd", 64'(wb_rd), 64'd7);
    chk1("sbyte_pulse_end", MEMWB_ready, 1'b0);
    tick();

    // Unsigned half load with junk above the half.
    mem_op(64'h102, 2'd1, 1'b1, 1'b1, 6'd9, 64'd0, 0, 2, 1'b1, 64'h1234_5678_9ABC_BEEF);
    @(negedge clk);
    chk64("uhalf_lit_data", wb_data, 64'h0000_0000_0000_BEEF);
    tick();

    // Signed word load, negative.
    mem_op(64'h108, 2'd2, 1'b0, 1'b1, 6'd10, 64'd0, 1, 1, 1'b1, 64'h1234_5678_8765_4321);
    @(negedge clk);
    chk64("sword_lit_data", wb_data, 64'hFFFF_FFFF_8765_4321);
    tick();

    // Dword load at minimum latency passes through.
    mem_op(64'h110, 2'd3, 1'b0, 1'b1, 6'd11, 64'd0, 0, 0, 1'b1, 64'h8000_0000_0000_0001);
    @(negedge clk);
    chk64("dword_lit_data", wb_data, 64'h8000_0000_0000_0001);
    tick();

    // Signed half load, positive; unsigned byte load, top bit set.
    mem_op(64'h11E, 2'd1, 1'b0, 1'b1, 6'd12, 64'd0, 0, 0, 1'b1, 64'hAAAA_AAAA_AAAA_7FFF);
    mem_op(64'h121, 2'd0, 1'b1, 1'b1, 6'd13, 64'd0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
    @(negedge clk);
    chk64("ubyte_lit_data", wb_data, 64'h0000_0000_0000_00F0);
    tick();

    // Store word.
    mem_op(64'h200, 2'd2, 1'b0, 1'b0, 6'd3, 64'hDEAD_BEEF, 1, 0, 1'b0, 64'd0);

    // Timeout: no response ever.
    mem_op(64'h300, 2'd3, 1'b0, 1'b1, 6'd14, 64'd0, 0, 0, 1'b0, 64'd0);

    // Store followed at once by a held non-memory entry: blocked while busy.
    EXMEM_ready    = 1'b1;
    mem_active     = 1'b1;
    load           = 1'b0;
    mem_size       = 2'd3;
    exmm_aluresult = 64'h208;
    dest_reg       = 6'd4;
    store_data     = 64'h0123_4567_89AB_CDEF;
    mem.req_ready  = 1'b1;
    push_exp(6'd0, 64'd0, 1'b0, 1'b0);
    push_exp(6'd15, 64'hFACE, 1'b1, 1'b0);
    tick();
    mem_active     = 1'b0;
    exmm_aluresult = 64'hFACE;
    dest_reg       = 6'd15;
    @(negedge clk);
    chk1("chain_req_valid", mem.req_valid, 1'b1);
    chk1("chain_busy", mem_busy, 1'b1);
    tick();
    @(negedge clk);
    chk1("chain_store_memwb", MEMWB_ready, 1'b1);
    chk64("chain_store_rd", 64'(wb_rd), 64'd0);
    chk1("chain_idle", mem_busy, 1'b0);
    tick();
    EXMEM_ready   = 1'b0;
    mem.req_ready = 1'b0;
    @(negedge clk);
    chk1("chain_alu_memwb", MEMWB_ready, 1'b1);
    chk64("chain_alu_rd", 64'(wb_rd), 64'd15);
    chk64("chain_alu_data", wb_data, 64'hFACE);
    tick();

    // Reset during WAIT_RESP, then a late response.
    EXMEM_ready    = 1'b1;
    mem_active     = 1'b1;
    load           = 1'b1;
    mem_size       = 2'd3;
    exmm_aluresult = 64'h400;
    dest_reg       = 6'd3;
    mem.req_ready  = 1'b1;
    tick();
    EXMEM_ready = 1'b0;
    tick();
    mem.req_ready = 1'b0;
    @(negedge clk);
    chk1("rwait_busy", mem_busy, 1'b1);
    reset = 1'b0;
    tick();
    reset          = 1'b1;
    mem.resp_valid = 1'b1;
    mem.resp_data  = 64'h55;
    @(negedge clk);
    chk1("rwait_idle", mem_busy, 1'b0);
    chk1("rwait_req_low", mem.req_valid, 1'b0);
    chk64("rwait_wb_rd", 64'(wb_rd), 64'd0);
    tick();
    mem.resp_valid = 1'b0;
    @(negedge clk);
    chk1("rwait_no_memwb", MEMWB_ready, 1'b0);
    chk1("rwait_still_idle", mem_busy, 1'b0);
    tick();

    // Reset during ISSUE drops req_valid at that edge.
    EXMEM_ready    = 1'b1;
    mem_active     = 1'b1;
    load           = 1'b0;
    mem_size       = 2'd0;
    exmm_aluresult = 64'h500;
    tick();
    EXMEM_ready = 1'b0;
    @(negedge clk);
    chk1("rissue_req_valid", mem.req_valid, 1'b1);
    reset = 1'b0;
    tick();
    reset         = 1'b1;
    mem.req_ready = 1'b1;
    @(negedge clk);
    chk1("rissue_req_low", mem.req_valid, 1'b0);
    chk1("rissue_idle", mem_busy, 1'b0);
    tick();
    mem.req_ready = 1'b0;
    @(negedge clk);
    chk1("rissue_no_memwb", MEMWB_ready, 1'b0);
    tick();

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    // Misaligned word load is retired with bus_err and never issued.
    EXMEM_ready    = 1'b1;
    mem_active     = 1'b1;
    load           = 1'b1;
    mem_size       = 2'd2;
    exmm_aluresult = 64'h102;
    dest_reg       = 6'd4;
    mem.req_ready  = 1'b1;
    push_exp(6'd0, 64'd0, 1'b0, 1'b1);
    tick();
    EXMEM_ready = 1'b0;
    @(negedge clk);
    chk1("mis_memwb", MEMWB_ready, 1'b1);
    chk1("mis_bus_err", bus_err, 1'b1);
    chk1("mis_idle", mem_busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk1("mis_req_low", mem.req_valid, 1'b0);
      tick();
      @(negedge clk);
    end
    mem.req_ready = 1'b0;
    tick();
`else
    // Without alignment checking a misaligned word load is issued unchanged.
    mem_op(64'h102, 2'd2, 1'b0, 1'b1, 6'd4, 64'd0, 0, 1, 1'b1, 64'h0000_0000_7000_0001);
    @(negedge clk);
    chk64("mis_issued_data", wb_data, 64'h0000_0000_7000_0001);
    tick();
`endif

    @(negedge clk);
    chk64("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline memory stage. Consumes the EX/MEM handoff from the execute stage: ALU result, destination register, memory-op flags and store data. Performs loads and stores on a single-outstanding request/response data-memory port, and produces the MEM/WB handoff. Its back-pressure output stalls the execute stage while a memory access is in flight.

## Interface
Parameters:
- MAX_WAIT, 255: cycles allowed in WAIT_RESP before a bus timeout (1..65535).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset==0 at a clk edge resets the block)
- EXMEM_ready  in  1  EX/MEM entry valid this cycle
- exmm_aluresult  in  64  ALU result, or effective address when mem_active=1
- dest_reg  in  6  destination register; 0 means no writeback
- mem_active  in  1  entry is a memory op
- load  in  1  1=load, 0=store (meaningful only with mem_active)
- mem_size  in  2  0=byte, 1=half, 2=word, 3=dword
- mem_unsigned  in  1  zero-extend load result
- store_data  in  64  rs2 value for stores
- mem_busy  out  1  stall to execute stage; entry not accepted while high
- req_valid  out  1  memory request valid
- req_ready  in  1  memory accepts request
- req_we  out  1  1=write
- req_addr  out  64  byte address
- req_size  out  2  copy of mem_size
- req_wdata  out  64  store data, right-aligned
- resp_valid  in  1  load data valid
- resp_data  in  64  load data, right-aligned, raw
- MEMWB_ready  out  1  one-cycle pulse: writeback entry valid
- wb_rd  out  6  writeback register
- wb_data  out  64  writeback value
- bus_err  out  1  one-cycle pulse on timeout or misaligned access

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP.
- Acceptance: the entry is accepted on an edge where EXMEM_ready=1 and mem_busy=0.
- Non-memory entry (mem_active=0): stays in IDLE. Next cycle: MEMWB_ready=1, wb_rd=dest_reg, wb_data=exmm_aluresult.
- Memory entry: latch the address, size, unsigned flag, rd, we=!load and wdata, then go to ISSUE.
- ISSUE: req_valid=1, with all req_* outputs stable until req_ready=1.
  - Store: on handshake, pulse MEMWB_ready with wb_rd=0 and return to IDLE.
  - Load: on handshake, go to WAIT_RESP and clear the wait counter.
- WAIT_RESP: increments the wait counter each cycle.
  - On resp_valid, pulse MEMWB_ready with wb_rd equal to the latched rd, then go to IDLE.
  - wb_data is resp_data extended from the access size: sign-extended when mem_unsigned=0, zero-extended when mem_unsigned=1. Dword loads pass through.
  - If the counter reaches MAX_WAIT without resp_valid: pulse bus_err and pulse MEMWB_ready with wb_rd=0, then go to IDLE.
- mem_busy=1 whenever state is not IDLE.
- resp_valid outside WAIT_RESP is ignored.
- wb_data and wb_rd hold their last value when MEMWB_ready=0.

## Timing
- Reset values: state IDLE; mem_busy=0, req_valid=0, req_we=0, req_addr=0, req_size=0, req_wdata=0, MEMWB_ready=0, wb_rd=0, wb_data=0, bus_err=0; wait counter 0.
- All outputs are registered.
- Non-memory latency: 1 cycle from acceptance to MEMWB_ready.
- Store latency: req_valid rises at acceptance+1; MEMWB_ready comes 1 cycle after the req handshake edge.
- Load latency: MEMWB_ready comes 1 cycle after the resp_valid edge.
  - Minimum is 3 cycles, when req_ready=1 immediately and resp_valid arrives the cycle after the handshake.
- Back-to-back: a non-memory entry can be accepted every cycle. After a memory op, the next entry is accepted on the first edge after the return to IDLE.
- Timeout: bus_err and MEMWB_ready assert together exactly MAX_WAIT cycles after entering WAIT_RESP.
- Reset mid-operation (any state) abandons the access: req_valid drops at that edge and no MEMWB_ready pulse is produced. A late resp_valid is ignored.

## Configuration
- MEM_ACCESS_MISALIGN_CHECK_EN defined:
  - A memory entry is misaligned when the address is not a multiple of the access size (half: addr[0]≠0; word: addr[1:0]≠0; dword: addr[2:0]≠0).
  - A misaligned entry is accepted but never issued. Next cycle: bus_err=1 and MEMWB_ready=1 with wb_rd=0, staying in IDLE.
- Not defined: no alignment checking; every access is issued unchanged.

## Test plan
- Reset: reset=0 for 2 cycles → every output is 0.
  - Then one non-memory entry: exmm_aluresult=0x1234, dest_reg=5 → next cycle MEMWB_ready=1, wb_rd=5, wb_data=0x1234.
- Signed byte load: addr 0x100, mem_size=0, mem_unsigned=0, dest_reg=7; memory returns resp_data=0x80 after req_ready was held low 3 cycles.
  - Required: req stays stable through the stall, mem_busy stays high throughout, and the result is wb_data=0xFFFFFFFFFFFFFF80, wb_rd=7.
- Unsigned half load: resp_data=0xBEEF → wb_data=0x000000000000BEEF.
- Store: addr 0x200, store_data=0xDEADBEEF, mem_size=2 → req_we=1, req_wdata=0xDEADBEEF, then MEMWB_ready with wb_rd=0.
- Timeout: MAX_WAIT=4 and resp_valid never asserted → bus_err and MEMWB_ready assert on the 4th cycle in WAIT_RESP with wb_rd=0; the block returns to IDLE.
- Reset during WAIT_RESP, then resp_valid=1 the cycle after → no MEMWB_ready pulse.
  - With MEM_ACCESS_MISALIGN_CHECK_EN: word load at 0x102 → bus_err=1 and req_valid never asserts.
